// File: rtl/token_ring_pkg.sv
// Shared definitions for the token ring controller: state encoding and default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package token_ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_PASS = 2'd2,
    ST_HOLD = 2'd3
  } ring_state_t;

  localparam int DEF_NUM_STATIONS = 4;
  localparam int DEF_MAX_HOLD     = 16;
  // Wide enough for any hold limit up to 255.
  localparam int HOLD_CNT_W       = 8;

endpackage

// File: rtl/token_hold_timer.sv
// Hold-duration counter for the current token holder, with limit compare.
// Latency: o_expired is combinational from the count register (high in the MAX_HOLD-th counted cycle).
// Backpressure: none; i_clear has priority over i_count.
// Ports: i_clk, i_reset_n (async, active-low), i_clear (zero the count), i_count (advance by one), o_expired.
module token_hold_timer
  import token_ring_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  logic [HOLD_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + HOLD_CNT_W'(1);
    end
  end

  // Count starts at 0 in the first hold cycle, so MAX_HOLD-1 marks the last allowed one.
  assign o_expired = (r_cnt == HOLD_CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/token_ring_ctrl.sv
// Token ring arbiter: circulates one token among NUM_STATIONS, granting a requester for up to MAX_HOLD cycles.
// Latency: grant rises one cycle after the token position with a pending request is sampled; all outputs registered.
// Backpressure: a holder keeps the token until release or expiry; stop during a hold is deferred to hold exit.
// Ports: i_clk, i_reset_n, i_start, i_stop, i_req[N], i_release[N] in; o_grant[N], o_tok_pos, o_busy, o_timeout out.
module token_ring_ctrl
  import token_ring_pkg::*;
#(
  parameter  int NUM_STATIONS = DEF_NUM_STATIONS,
  parameter  int MAX_HOLD     = DEF_MAX_HOLD,
  localparam int PW           = $clog2(NUM_STATIONS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [NUM_STATIONS-1:0] i_req,
  input  logic [NUM_STATIONS-1:0] i_release,
  output logic [NUM_STATIONS-1:0] o_grant,
  output logic [PW-1:0]           o_tok_pos,
  output logic                    o_busy,
  output logic                    o_timeout
);

  ring_state_t             r_state, w_state_nxt;
  logic [PW-1:0]           r_tok_pos, w_tok_pos_nxt;
  logic [NUM_STATIONS-1:0] r_grant, w_grant_nxt;
  logic                    r_busy, r_timeout, w_timeout_nxt;
  logic                    r_stop_pend, w_stop_pend_nxt;
  logic                    w_req_hit, w_rel_hit, w_expired, w_hold_exit;
  logic                    w_tmr_clear, w_tmr_count;

  assign w_req_hit   = i_req[r_tok_pos];
  // Only the holder's release bit matters, and only while holding.
  assign w_rel_hit   = i_release[r_tok_pos];
  assign w_hold_exit = (r_state == ST_HOLD) && (w_rel_hit || w_expired);
  assign w_tmr_clear = (r_state == ST_SEED) || w_hold_exit;
  assign w_tmr_count = (r_state == ST_HOLD);

  token_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_tmr_clear),
    .i_count   (w_tmr_count),
    .o_expired (w_expired)
  );

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_tok_pos   <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tok_pos   <= w_tok_pos_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_timeout   <= w_timeout_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start && !i_stop) w_state_nxt = ST_SEED;
      ST_SEED: w_state_nxt = i_stop ? ST_IDLE : ST_PASS;
      ST_PASS: begin
        if (i_stop)         w_state_nxt = ST_IDLE;
        else if (w_req_hit) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // A stop seen in the exit cycle itself counts as pending too.
        if (w_hold_exit) w_state_nxt = (r_stop_pend || i_stop) ? ST_IDLE : ST_PASS;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_tok_pos_nxt   = r_tok_pos;
    w_grant_nxt     = '0;
    w_timeout_nxt   = w_hold_exit && !w_rel_hit;
    w_stop_pend_nxt = r_stop_pend;

    case (r_state)
      ST_SEED: w_tok_pos_nxt = '0;
      ST_PASS: if (!i_stop && !w_req_hit) w_tok_pos_nxt = r_tok_pos + PW'(1);
      ST_HOLD: if (w_hold_exit) w_tok_pos_nxt = r_tok_pos + PW'(1);
      default: ;
    endcase

    // tok_pos does not move on entry to or during HOLD, so this is the holder.
    if (w_state_nxt == ST_HOLD) w_grant_nxt = NUM_STATIONS'(1) << w_tok_pos_nxt;

    if (w_state_nxt == ST_IDLE)                w_stop_pend_nxt = 1'b0;
    else if (r_state == ST_HOLD && i_stop)     w_stop_pend_nxt = 1'b1;
  end

  assign o_grant   = r_grant;
  assign o_tok_pos = r_tok_pos;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule
